multicycle_controller: RTL and testbench

Sequencing controller for the multicycle variant of the RV32I core: it takes the datapath's shared ALU and unified instruction/data memory port through each instruction, one state per cycle. It decodes `op`/`funct3`/`funct7b5` from the instruction register and drives every datapath select and write enable. It stalls on a memory ready handshake, traps on unsupported opcodes, and counts retired instructions.

---
 rtl/multicycle_controller_if.sv | 48 ++++
 rtl/multicycle_controller.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// ----------------------------------------------------------------------------
// multicycle_controller_if
// Bundles the decode inputs, the status handshake and every control output
// that passes between the multicycle RV32I controller and its datapath.
//
// Signals (direction as seen by the controller, modport master):
//   op[6:0], funct3[2:0], funct7b5  in  : instruction fields from the IR
//   Zero, MemReady                  in  : ALU zero flag, memory completes now
//   PCWrite, AdrSrc, MemWrite,      out : datapath enables and selects
//   IRWrite, RegWrite, ResultSrc,
//   ALUSrcA, ALUSrcB, ImmSrc,
//   ALUControl
//   Trap                            out : illegal opcode seen (sticky)
//   InstrRetired[31:0]              out : retired-instruction count
// The slave modport is the datapath side (it drives the decode inputs).
// ----------------------------------------------------------------------------
interface multicycle_controller_if;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        MemReady;

    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [2:0]  ALUControl;
    logic        Trap;
    logic [31:0] InstrRetired;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Trap, InstrRetired
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Trap, InstrRetired
    );
endinterface

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
// Sequencing FSM for the multicycle RV32I core. Walks each instruction through
// FETCH/DECODE and the per-class execute states, one state per cycle, stalling
// on MemReady in FETCH, MEMREAD and MEMWRITE. Unsupported opcodes park the
// FSM in ERROR (Trap=1) until reset. Counts retired instructions.
//
// Ports:
//   clk     in  : rising-edge clock
//   reset   in  : synchronous, active-high
//   ctl_bus     : multicycle_controller_if.master (decode in, controls out)
// ----------------------------------------------------------------------------
module multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       ctl_bus
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_ERROR
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_retired;
    logic        w_retire;
    logic [2:0]  w_alu_decoded;

    logic        w_pc_write;
    logic        w_mem_write;
    logic        w_ir_write;
    logic        w_reg_write;
    logic        w_adr_src;
    logic [1:0]  w_result_src;
    logic [1:0]  w_alu_src_a;
    logic [1:0]  w_alu_src_b;
    logic [2:0]  w_alu_control;

    // NOTE: state and counter are clocked registers, so they use non-blocking
    // assignments; everything feeding them is built combinationally below.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + 32'd1;
        end
    end

    // ALU operation for EXECR/EXECI; op[5] separates R-type (sub allowed)
    // from I-type, where bit 30 is part of the immediate.
    always_comb begin
        unique case (ctl_bus.funct3)
            3'b000:  w_alu_decoded = (ctl_bus.op[5] && ctl_bus.funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  w_alu_decoded = ALU_SLT;
            3'b110:  w_alu_decoded = ALU_OR;
            3'b111:  w_alu_decoded = ALU_AND;
            default: w_alu_decoded = ALU_ADD;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        w_pc_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_adr_src     = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_alu_control = ALU_ADD;

        unique case (r_state)
            S_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = ctl_bus.MemReady;
                w_pc_write   = ctl_bus.MemReady;
                if (ctl_bus.MemReady)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                unique case (ctl_bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = (ctl_bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                if (ctl_bus.MemReady)
                    w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (ctl_bus.MemReady) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXECR: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = w_alu_decoded;
                w_next        = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_alu_control = w_alu_decoded;
                w_next        = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
                w_next      = S_ALUWB;
            end
            S_BEQ: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = ALU_SUB;
                w_pc_write    = ctl_bus.Zero;
                w_retire      = 1'b1;
                w_next        = S_FETCH;
            end
            S_ERROR: begin
                w_next = S_ERROR;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Enables are masked during reset so an abandoned instruction writes nothing.
    assign ctl_bus.PCWrite      = w_pc_write  & ~reset;
    assign ctl_bus.MemWrite     = w_mem_write & ~reset;
    assign ctl_bus.IRWrite      = w_ir_write  & ~reset;
    assign ctl_bus.RegWrite     = w_reg_write & ~reset;
    assign ctl_bus.AdrSrc       = w_adr_src;
    assign ctl_bus.ResultSrc    = w_result_src;
    assign ctl_bus.ALUSrcA      = w_alu_src_a;
    assign ctl_bus.ALUSrcB      = w_alu_src_b;
    assign ctl_bus.ALUControl   = w_alu_control;
    assign ctl_bus.Trap         = (r_state == S_ERROR);
    assign ctl_bus.InstrRetired = r_retired;

    // Immediate format follows the opcode in every state.
    assign ctl_bus.ImmSrc = (ctl_bus.op == OP_SW)  ? 2'b01 :
                            (ctl_bus.op == OP_BEQ) ? 2'b10 :
                            (ctl_bus.op == OP_JAL) ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
// Self-checking bench for multicycle_controller. For each cycle of an
// instruction the bench derives the expected control word and retired count
// from its own per-step table, pushes it into a scoreboard when the inputs are
// driven, and pops/compares it at the falling edge.
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk     (clk),
        .reset   (reset),
        .ctl_bus (bus)
    );

    always #5 clk = ~clk;

    typedef enum {
        K_FETCH, K_DECODE, K_MEMADR, K_MEMREAD, K_MEMWB, K_MEMWRITE,
        K_EXECR, K_EXECI, K_ALUWB, K_JAL, K_BEQ, K_ERROR
    } kind_e;

    typedef struct {
        kind_e k;
        bit    rdy;
    } step_t;

    typedef struct {
        string       tag;
        logic [16:0] word;
        logic [31:0] retired;
    } exp_t;

    exp_t        scoreboard[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_retired = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Trap}
    function automatic logic [16:0] dut_word();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.Trap};
    endfunction

    function automatic logic [2:0] exp_alu(input logic [6:0] op, input logic [2:0] f3, input bit f7);
        case (f3)
            3'b000:  return (op[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [16:0] exp_word(input kind_e k, input bit rdy, input bit zero,
                                             input logic [6:0] op, input logic [2:0] f3, input bit f7);
        logic       pcw, adr, mw, irw, rw, trap;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; trap = 0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
        if (op == 7'b0100011)      imm = 2'b01;
        else if (op == 7'b1100011) imm = 2'b10;
        else if (op == 7'b1101111) imm = 2'b11;
        else                       imm = 2'b00;
        case (k)
            K_FETCH:    begin sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            K_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            K_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            K_MEMREAD:  begin adr = 1; end
            K_MEMWB:    begin rs = 2'b01; rw = 1; end
            K_MEMWRITE: begin adr = 1; mw = 1; end
            K_EXECR:    begin sa = 2'b10; sb = 2'b00; alu = exp_alu(op, f3, f7); end
            K_EXECI:    begin sa = 2'b10; sb = 2'b01; alu = exp_alu(op, f3, f7); end
            K_ALUWB:    begin rw = 1; end
            K_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            K_BEQ:      begin sa = 2'b10; sb = 2'b00; alu = 3'b001; pcw = zero; end
            K_ERROR:    begin trap = 1; end
            default:    begin end
        endcase
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, trap};
    endfunction

    // Entry/exit point: #1 after a rising edge, at the start of a cycle.
    task automatic apply_reset(input int n, input logic [31:0] instr);
        reset = 1'b1;
        bus.op = instr[6:0]; bus.funct3 = instr[14:12]; bus.funct7b5 = instr[30];
        for (int i = 0; i < n; i++) begin
            bus.MemReady = 1'($urandom_range(0, 1));
            bus.Zero     = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("reset_enables[%0d]", i),
                  {28'd0, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}, 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        model_retired = '0;
        check("reset_retired", bus.InstrRetired, 32'd0);
        check("reset_trap", {31'd0, bus.Trap}, 32'd0);
    endtask

    // max_steps < 0 runs the whole instruction; otherwise stops early so a
    // reset can cut it off.
    task automatic run_instr(input string name, input logic [31:0] instr, input bit zero,
                             input int fstall, input int mstall, input int nerr, input int max_steps);
        step_t       seq[$];
        logic [6:0]  op;
        logic [2:0]  f3;
        bit          f7;
        exp_t        e;
        op = instr[6:0]; f3 = instr[14:12]; f7 = instr[30];
        for (int i = 0; i < fstall; i++) seq.push_back('{K_FETCH, 1'b0});
        seq.push_back('{K_FETCH, 1'b1});
        seq.push_back('{K_DECODE, 1'($urandom_range(0, 1))});
        case (op)
            7'b0000011: begin
                seq.push_back('{K_MEMADR, 1'($urandom_range(0, 1))});
                for (int i = 0; i < mstall; i++) seq.push_back('{K_MEMREAD, 1'b0});
                seq.push_back('{K_MEMREAD, 1'b1});
                seq.push_back('{K_MEMWB, 1'($urandom_range(0, 1))});
            end
            7'b0100011: begin
                seq.push_back('{K_MEMADR, 1'($urandom_range(0, 1))});
                for (int i = 0; i < mstall; i++) seq.push_back('{K_MEMWRITE, 1'b0});
                seq.push_back('{K_MEMWRITE, 1'b1});
            end
            7'b0110011: begin
                seq.push_back('{K_EXECR, 1'($urandom_range(0, 1))});
                seq.push_back('{K_ALUWB, 1'($urandom_range(0, 1))});
            end
            7'b0010011: begin
                seq.push_back('{K_EXECI, 1'($urandom_range(0, 1))});
                seq.push_back('{K_ALUWB, 1'($urandom_range(0, 1))});
            end
            7'b1100011: seq.push_back('{K_BEQ, 1'($urandom_range(0, 1))});
            7'b1101111: begin
                seq.push_back('{K_JAL, 1'($urandom_range(0, 1))});
                seq.push_back('{K_ALUWB, 1'($urandom_range(0, 1))});
            end
            default: for (int i = 0; i < nerr; i++) seq.push_back('{K_ERROR, 1'($urandom_range(0, 1))});
        endcase

        for (int s = 0; s < seq.size(); s++) begin
            if (max_steps >= 0 && s >= max_steps) break;
            bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
            bus.Zero     = zero;
            bus.MemReady = seq[s].rdy;
            e.tag     = $sformatf("%s/c%0d/%s", name, s + 1, seq[s].k.name());
            e.word    = exp_word(seq[s].k, seq[s].rdy, zero, op, f3, f7);
            e.retired = model_retired;
            scoreboard.push_back(e);
            if (seq[s].k == K_MEMWB || seq[s].k == K_ALUWB || seq[s].k == K_BEQ ||
                (seq[s].k == K_MEMWRITE && seq[s].rdy))
                model_retired++;

            @(negedge clk);
            e = scoreboard.pop_front();
            check({e.tag, "/ctl"}, {15'd0, dut_word()}, {15'd0, e.word});
            check({e.tag, "/retired"}, bus.InstrRetired, e.retired);
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] itype(input logic [2:0] f3, input logic [11:0] imm);
        return {imm, 5'd1, f3, 5'd2, 7'b0010011};
    endfunction

    function automatic logic [31:0] rtype(input logic [2:0] f3, input bit f7b5);
        return {1'b0, f7b5, 5'd0, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    initial begin
        reset = 1'b1;
        bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0; bus.MemReady = 1'b0;
        @(posedge clk); #1;

        apply_reset(2, 32'h002081B3);
        run_instr("add",   32'h002081B3, 1'b0, 0, 0, 0, -1);
        check("add_retired_total", bus.InstrRetired, 32'd1);

        run_instr("lw_stall", 32'h00402283, 1'b0, 0, 3, 0, -1);
        run_instr("sw",       32'h00502223, 1'b0, 0, 0, 0, -1);
        run_instr("beq_t",    32'h00208463, 1'b1, 0, 0, 0, -1);
        run_instr("beq_nt",   32'h00208463, 1'b0, 0, 0, 0, -1);
        run_instr("sub",      32'h402081B3, 1'b0, 0, 0, 0, -1);
        run_instr("jal",      32'h0080006F, 1'b1, 0, 0, 0, -1);
        run_instr("slt",      rtype(3'b010, 1'b0), 1'b0, 0, 0, 0, -1);
        run_instr("and",      rtype(3'b111, 1'b0), 1'b0, 0, 0, 0, -1);
        run_instr("xor_add",  rtype(3'b100, 1'b1), 1'b0, 0, 0, 0, -1);
        run_instr("addi_b30", itype(3'b000, 12'h400), 1'b0, 0, 0, 0, -1);
        run_instr("ori",      itype(3'b110, 12'h005), 1'b0, 0, 0, 0, -1);
        run_instr("slti",     itype(3'b010, 12'h005), 1'b0, 0, 0, 0, -1);
        run_instr("andi",     itype(3'b111, 12'h0FF), 1'b0, 0, 0, 0, -1);
        run_instr("sw_stall", 32'h00502223, 1'b0, 2, 2, 0, -1);
        run_instr("lw",       32'h00402283, 1'b1, 1, 0, 0, -1);
        check("retired_total", bus.InstrRetired, 32'd16);

        // Cut off an add just as it reaches ALUWB: the write must not happen.
        run_instr("add_abort", 32'h002081B3, 1'b0, 0, 0, 0, 3);
        apply_reset(1, 32'h002081B3);

        run_instr("illegal", 32'h0000007F, 1'b1, 0, 0, 4, -1);
        check("illegal_retired", bus.InstrRetired, 32'd0);
        apply_reset(2, 32'h00208463);
        run_instr("beq_after", 32'h00208463, 1'b1, 0, 0, 0, -1);
        check("after_trap_retired", bus.InstrRetired, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
